// File: rtl/pcpi_cmd_initiator_pkg.sv
// Shared constants for the PCPI command initiator: instruction encoding,
// command opcodes, response error codes and the FSM state type.
package pcpi_cmd_initiator_pkg;

    localparam int unsigned DEF_DWIDTH = 16;
    localparam int unsigned DEF_AWIDTH = 10;

    localparam logic [6:0] INSN_OPCODE = 7'b1011011;
    localparam logic [6:0] INSN_FUNCT7 = 7'b0000001;

    localparam logic [2:0] OP_LOAD    = 3'b001;
    localparam logic [2:0] OP_WEIGHT  = 3'b010;
    localparam logic [2:0] OP_COMPUTE = 3'b100;
    localparam logic [2:0] OP_READ    = 3'b101;

    localparam logic [1:0] ERR_OK      = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_NOWAIT  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } init_state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op inside {OP_LOAD, OP_WEIGHT, OP_COMPUTE, OP_READ};
    endfunction

    function automatic logic [31:0] build_insn(input logic [2:0] op);
        return {INSN_FUNCT7, 10'b0, op, 5'b0, INSN_OPCODE};
    endfunction

endpackage

// File: rtl/pcpi_cmd_initiator_timer.sv
// Saturating cycle counter with synchronous clear; hit flags the enabled
// cycle on which the count reaches LIMIT.
module pcpi_init_timer #(
    parameter int unsigned LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic hit
);

    localparam int unsigned   CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] LIM  = CW'(LIMIT);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != LIM)) begin
            count <= count + CW'(1);
        end
    end

    // Asserted in the cycle whose increment lands on LIMIT, so the caller
    // can leave its state exactly LIMIT cycles after the clear.
    assign hit = en && (count >= LAST);

endmodule

// File: rtl/pcpi_cmd_initiator.sv
// PCPI host-side initiator: turns one command handshake into one PCPI
// transaction and returns a response. Optional watchdog: PCPI_INIT_TIMEOUT_EN.
module pcpi_cmd_initiator
    import pcpi_cmd_initiator_pkg::*;
#(
    parameter int unsigned DWIDTH         = DEF_DWIDTH,
    parameter int unsigned AWIDTH         = DEF_AWIDTH,
    parameter int unsigned NOWAIT_LIMIT   = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [AWIDTH-1:0] cmd_addr,
    input  logic [DWIDTH-1:0] cmd_data,
    output logic              pcpi_valid,
    output logic [31:0]       pcpi_insn,
    output logic [31:0]       pcpi_rs1,
    output logic [31:0]       pcpi_rs2,
    input  logic              pcpi_wr,
    input  logic [31:0]       pcpi_rd,
    input  logic              pcpi_wait,
    input  logic              pcpi_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DWIDTH-1:0] rsp_data,
    output logic [1:0]        rsp_err,
    output logic              busy
);

    init_state_t       state, state_n;
    logic [2:0]        op_q;
    logic [AWIDTH-1:0] addr_q;
    logic [DWIDTH-1:0] data_q;
    logic [DWIDTH-1:0] rsp_data_q, rsp_data_n;
    logic [1:0]        rsp_err_q, rsp_err_n;
    logic              valid_q;
    logic              load_cmd;
    logic              done;
    logic              timer_clr;
    logic              nowait_en, nowait_hit;
    logic              wdog_hit;
    logic              unused_rd_hi;

    assign done         = pcpi_ready | pcpi_wr;
    assign timer_clr    = (state == ST_IDLE);
    assign nowait_en    = (state == ST_ISSUE) && !done && !pcpi_wait;
    assign unused_rd_hi = ^pcpi_rd[31:DWIDTH];

    pcpi_init_timer #(
        .LIMIT(NOWAIT_LIMIT)
    ) u_nowait_timer (
        .clk(clk),
        .rst(rst),
        .clr(timer_clr),
        .en (nowait_en),
        .hit(nowait_hit)
    );

`ifdef PCPI_INIT_TIMEOUT_EN
    logic wdog_en;
    assign wdog_en = (state == ST_WAIT) && !done;

    pcpi_init_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdog_timer (
        .clk(clk),
        .rst(rst),
        .clr(timer_clr),
        .en (wdog_en),
        .hit(wdog_hit)
    );
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        rsp_data_n = rsp_data_q;
        rsp_err_n  = rsp_err_q;
        load_cmd   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    rsp_data_n = '0;
                    if (is_legal_op(cmd_op)) begin
                        state_n   = ST_ISSUE;
                        load_cmd  = 1'b1;
                        rsp_err_n = ERR_OK;
                    end else begin
                        state_n   = ST_RESP;
                        rsp_err_n = ERR_ILLEGAL;
                    end
                end
            end
            ST_ISSUE: begin
                if (done) begin
                    state_n    = ST_RESP;
                    rsp_err_n  = ERR_OK;
                    rsp_data_n = pcpi_wr ? pcpi_rd[DWIDTH-1:0] : '0;
                end else if (pcpi_wait) begin
                    state_n = ST_WAIT;
                end else if (nowait_hit) begin
                    state_n    = ST_RESP;
                    rsp_err_n  = ERR_NOWAIT;
                    rsp_data_n = '0;
                end
            end
            ST_WAIT: begin
                // Completion is checked first so it wins over a same-cycle expiry.
                if (done) begin
                    state_n    = ST_RESP;
                    rsp_err_n  = ERR_OK;
                    rsp_data_n = pcpi_wr ? pcpi_rd[DWIDTH-1:0] : '0;
                end else if (wdog_hit) begin
                    state_n    = ST_RESP;
                    rsp_err_n  = ERR_TIMEOUT;
                    rsp_data_n = '0;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_n    = ST_IDLE;
                    rsp_err_n  = ERR_OK;
                    rsp_data_n = '0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            op_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
            valid_q    <= 1'b0;
        end else begin
            state      <= state_n;
            rsp_data_q <= rsp_data_n;
            rsp_err_q  <= rsp_err_n;
            valid_q    <= (state_n == ST_ISSUE) || (state_n == ST_WAIT);
            if (load_cmd) begin
                op_q   <= cmd_op;
                addr_q <= cmd_addr;
                data_q <= cmd_data;
            end
        end
    end

    assign cmd_ready  = (state == ST_IDLE);
    assign rsp_valid  = (state == ST_RESP);
    assign busy       = (state != ST_IDLE);
    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign pcpi_valid = valid_q;
    assign pcpi_insn  = valid_q ? build_insn(op_q) : '0;
    assign pcpi_rs1   = valid_q ? 32'(addr_q) : '0;
    assign pcpi_rs2   = valid_q ? 32'(data_q) : '0;

endmodule

// File: tb/tb_pcpi_cmd_initiator.sv
// Directed bench for pcpi_cmd_initiator: stimulus pushes expected responses,
// a negedge monitor pops and compares them on each consumed response.
module tb_pcpi_cmd_initiator;
    import pcpi_cmd_initiator_pkg::*;

`ifdef PCPI_INIT_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 8;
`else
    localparam int unsigned TB_TIMEOUT = 4096;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [9:0]  cmd_addr;
    logic [15:0] cmd_data;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_err;
    logic        busy;

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  err;
    } rsp_t;

    rsp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    pcpi_cmd_initiator #(
        .DWIDTH(16),
        .AWIDTH(10),
        .NOWAIT_LIMIT(16),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_addr(cmd_addr),
        .cmd_data(cmd_data),
        .pcpi_valid(pcpi_valid),
        .pcpi_insn(pcpi_insn),
        .pcpi_rs1(pcpi_rs1),
        .pcpi_rs2(pcpi_rs2),
        .pcpi_wr(pcpi_wr),
        .pcpi_rd(pcpi_rd),
        .pcpi_wait(pcpi_wait),
        .pcpi_ready(pcpi_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] d, input logic [1:0] e);
        rsp_t r;
        r.data = d;
        r.err  = e;
        sb.push_back(r);
    endtask

    // Returns 1ns into the cycle after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [9:0] a, input logic [15:0] d);
        int unsigned n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        while (!cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_addr  = '0;
        cmd_data  = '0;
    endtask

    task automatic check_reset_outputs(input string p);
        check({p, "_cmd_ready"},  32'(cmd_ready),  32'd1);
        check({p, "_pcpi_valid"}, 32'(pcpi_valid), 32'd0);
        check({p, "_pcpi_insn"},  pcpi_insn,       32'd0);
        check({p, "_pcpi_rs1"},   pcpi_rs1,        32'd0);
        check({p, "_pcpi_rs2"},   pcpi_rs2,        32'd0);
        check({p, "_rsp_valid"},  32'(rsp_valid),  32'd0);
        check({p, "_rsp_data"},   32'(rsp_data),   32'd0);
        check({p, "_rsp_err"},    32'(rsp_err),    32'd0);
        check({p, "_busy"},       32'(busy),       32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: got data=%h err=%h, want no response", rsp_data, rsp_err);
            end else begin
                rsp_t e;
                e = sb.pop_front();
                check("rsp_data", 32'(rsp_data), 32'(e.data));
                check("rsp_err",  32'(rsp_err),  32'(e.err));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, want finish before 100us");
        $fatal(1);
    end

    initial begin
        int unsigned n;
        logic        seen;

        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_addr = '0; cmd_data = '0;
        pcpi_wr = 1'b0; pcpi_rd = '0; pcpi_wait = 1'b0; pcpi_ready = 1'b0;
        rsp_ready = 1'b1;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // LOAD: wait at cycle 1, ready at cycle 4, response at cycle 5.
        push_exp(16'h0000, ERR_OK);
        send(OP_LOAD, 10'd5, 16'h00AB);
        check("load_valid_c1", 32'(pcpi_valid), 32'd1);
        check("load_insn", pcpi_insn, 32'h0200105B);
        check("load_rs1", pcpi_rs1, 32'd5);
        check("load_rs2", pcpi_rs2, 32'h000000AB);
        pcpi_wait = 1'b1;
        tick(); tick();
        check("load_valid_c3", 32'(pcpi_valid), 32'd1);
        check("load_rsp_valid_c3", 32'(rsp_valid), 32'd0);
        tick();
        pcpi_ready = 1'b1;
        tick();
        pcpi_ready = 1'b0; pcpi_wait = 1'b0;
        check("load_valid_c5", 32'(pcpi_valid), 32'd0);
        check("load_rsp_valid_c5", 32'(rsp_valid), 32'd1);
        tick();
        check("load_back_idle", 32'(cmd_ready), 32'd1);

        // READ completed by pcpi_wr alone.
        push_exp(16'h1234, ERR_OK);
        send(OP_READ, 10'd3, 16'h0000);
        check("read_insn", pcpi_insn, 32'h0200505B);
        check("read_rs1", pcpi_rs1, 32'd3);
        pcpi_wr = 1'b1; pcpi_rd = 32'h00001234;
        tick();
        pcpi_wr = 1'b0; pcpi_rd = '0;
        check("read_rsp_valid", 32'(rsp_valid), 32'd1);
        check("read_valid_dropped", 32'(pcpi_valid), 32'd0);
        tick();
        check("read_closed", 32'(busy), 32'd0);

        // Ready and wr together from WAIT: one completion, low half of rd kept.
        push_exp(16'h5678, ERR_OK);
        send(OP_READ, 10'd1, 16'h0000);
        pcpi_wait = 1'b1;
        tick();
        pcpi_wait = 1'b0; pcpi_wr = 1'b1; pcpi_ready = 1'b1; pcpi_rd = 32'hDEAD5678;
        tick();
        pcpi_wr = 1'b0; pcpi_ready = 1'b0; pcpi_rd = '0;
        check("both_rsp_valid", 32'(rsp_valid), 32'd1);
        tick(); tick();
        check("both_single_rsp", 32'(rsp_valid), 32'd0);

        // Illegal op: response next cycle, PCPI never driven.
        push_exp(16'h0000, ERR_ILLEGAL);
        send(3'b111, 10'd7, 16'h0055);
        check("illegal_rsp_valid", 32'(rsp_valid), 32'd1);
        check("illegal_insn", pcpi_insn, 32'd0);
        seen = pcpi_valid;
        for (int i = 0; i < 4; i++) begin
            tick();
            seen = seen | pcpi_valid;
        end
        check("illegal_no_pcpi_valid", 32'(seen), 32'd0);

        // Silent responder: exactly NOWAIT_LIMIT cycles of pcpi_valid.
        push_exp(16'h0000, ERR_NOWAIT);
        send(OP_COMPUTE, 10'd1, 16'h0002);
        n = 0;
        while (pcpi_valid && n < 40) begin
            n++;
            tick();
        end
        check("nowait_valid_cycles", n, 32'd16);
        check("nowait_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();

        // Wait on the last no-wait cycle takes priority over the limit.
        push_exp(16'h0000, ERR_OK);
        send(OP_WEIGHT, 10'd9, 16'h1111);
        repeat (15) tick();
        check("limit_edge_valid", 32'(pcpi_valid), 32'd1);
        pcpi_wait = 1'b1;
        tick();
        pcpi_wait = 1'b0;
        check("limit_edge_still_valid", 32'(pcpi_valid), 32'd1);
        check("limit_edge_no_rsp", 32'(rsp_valid), 32'd0);
        pcpi_ready = 1'b1;
        tick();
        pcpi_ready = 1'b0;
        check("limit_edge_rsp", 32'(rsp_valid), 32'd1);
        tick();

`ifdef PCPI_INIT_TIMEOUT_EN
        // Watchdog expiry after 8 WAIT cycles.
        push_exp(16'h0000, ERR_TIMEOUT);
        send(OP_COMPUTE, 10'd2, 16'h0003);
        pcpi_wait = 1'b1;
        n = 0;
        while (pcpi_valid && n < 40) begin
            n++;
            tick();
        end
        pcpi_wait = 1'b0;
        check("wdog_valid_cycles", n, 32'd9);
        check("wdog_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();

        // Ready on the 8th WAIT cycle beats the expiry.
        push_exp(16'h0000, ERR_OK);
        send(OP_COMPUTE, 10'd2, 16'h0003);
        pcpi_wait = 1'b1;
        repeat (8) tick();
        pcpi_ready = 1'b1;
        tick();
        pcpi_ready = 1'b0; pcpi_wait = 1'b0;
        check("wdog_race_rsp_valid", 32'(rsp_valid), 32'd1);
        tick();
`endif

        // Backpressure: response held for 10 cycles, next command blocked.
        push_exp(16'h0077, ERR_OK);
        send(OP_WEIGHT, 10'd4, 16'h0077);
        rsp_ready = 1'b0;
        pcpi_wr = 1'b1; pcpi_rd = 32'h00000077;
        tick();
        pcpi_wr = 1'b0; pcpi_rd = '0;
        cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_addr = 10'd8; cmd_data = 16'h0042;
        for (int i = 0; i < 10; i++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_data", 32'(rsp_data), 32'h77);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("bp_idle_ready", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("second_valid", 32'(pcpi_valid), 32'd1);
        check("second_insn", pcpi_insn, 32'h0200105B);
        check("second_rs2", pcpi_rs2, 32'h00000042);
        pcpi_wait = 1'b1;
        tick(); tick();
        check("second_mid_wait", 32'(pcpi_valid), 32'd1);
        rsp_ready = 1'b0;
        rst = 1'b1;
        tick();
        check_reset_outputs("midwait_reset");
        pcpi_wait = 1'b0; rst = 1'b0; rsp_ready = 1'b1;
        tick();

        // Pending response discarded by reset.
        rsp_ready = 1'b0;
        send(OP_READ, 10'd2, 16'h0000);
        pcpi_wr = 1'b1; pcpi_rd = 32'h0000BEEF;
        tick();
        pcpi_wr = 1'b0; pcpi_rd = '0;
        check("pending_rsp_data", 32'(rsp_data), 32'h0000BEEF);
        rst = 1'b1;
        tick();
        check_reset_outputs("pending_reset");
        rst = 1'b0; rsp_ready = 1'b1;
        tick(); tick();
        check("pending_dropped", 32'(rsp_valid), 32'd0);

        check("scoreboard_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
